// File: rtl/gba_fb_pkg.sv
// Shared constants, write-FSM encoding and FIFO entry layout for the framebuffer writer.
package gba_fb_pkg;

    localparam int unsigned FB_W            = 240;
    localparam int unsigned FB_H            = 160;
    localparam int unsigned WORDS_PER_FRAME = (FB_W * FB_H) / 4;
    localparam int unsigned IDX_W           = 14;
    localparam int unsigned PIX_W           = 15;
    localparam int unsigned DATA_W          = 64;
    localparam int unsigned ADDR_W          = 27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } wr_state_e;

    // One completed word, tagged with the buffer and word index it belongs to
    typedef struct packed {
        logic                 fb_sel;
        logic [IDX_W-1:0]     idx;
        logic [DATA_W-1:0]    data;
    } fb_word_t;

    localparam int unsigned ENTRY_W = 1 + IDX_W + DATA_W;

endpackage

// File: rtl/gba_fb_if.sv
// Pixel input, DDRAM channel-5 write port and frame status of the framebuffer writer.
interface gba_fb_if;
    import gba_fb_pkg::*;

    logic              frame_start;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;
    logic [ADDR_W-1:0] ch5_addr;
    logic [DATA_W-1:0] ch5_din;
    logic              ch5_req;
    logic              ch5_ready;
    logic              display_buf;
    logic              frame_done;

    modport slave (
        input  frame_start, pix_valid, pix_data, ch5_ready,
        output pix_ready, ch5_addr, ch5_din, ch5_req, display_buf, frame_done
    );

    modport master (
        output frame_start, pix_valid, pix_data, ch5_ready,
        input  pix_ready, ch5_addr, ch5_din, ch5_req, display_buf, frame_done
    );

endinterface

// File: rtl/gba_fb_fifo.sv
// Small synchronous FIFO of completed words; push and pop may coincide even when full.
module gba_fb_fifo #(
    parameter int unsigned WIDTH = 79,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign do_pop  = pop & ~empty_c;
    assign do_push = push & (~full_c | do_pop);
    assign dout_c  = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gba_fb_writer.sv
// Packs GBA pixels four per word, queues them and writes them to DDRAM channel 5,
// double-buffering complete frames for scanout.
module gba_fb_writer
    import gba_fb_pkg::*;
#(
    parameter logic [27:0] FB_BASE0   = 28'h1000000,
    parameter logic [27:0] FB_BASE1   = 28'h1020000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     DDRAM_CLK,
    input  logic     DDRAM_RESET_N,
    gba_fb_if.slave  fb
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_REQ  = 2'(REQ);
    localparam logic [1:0] ST_WAIT = 2'(WAIT);

    logic [1:0]        lane;
    logic [IDX_W-1:0]  idx;
    logic [47:0]       pack_q;
    fb_word_t          stg_q;
    logic              stg_valid;
    logic              write_buf;
    logic              display_buf_q;
    logic              frame_done_q;
    logic [1:0]        state;
    logic [1:0]        state_d;
    logic              req_d;
    logic              load;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    fb_word_t          head;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [ADDR_W-1:0] wr_addr;
    logic              pix_accept;
    logic              frame_over;
    logic              ack_last;
    logic              done_eff;

    assign fb.pix_ready   = ~(fifo_full & (lane == 2'd3));
    assign fb.ch5_req     = req_q;
    assign fb.ch5_addr    = addr_q;
    assign fb.ch5_din     = din_q;
    assign fb.display_buf = display_buf_q;
    assign fb.frame_done  = frame_done_q;

    assign pix_accept = fb.pix_valid & fb.pix_ready;
    assign frame_over = (idx >= IDX_W'(WORDS_PER_FRAME));
    assign ack_last   = fifo_pop & (head.idx == IDX_W'(WORDS_PER_FRAME - 1))
                                 & (head.fb_sel == write_buf);
    assign done_eff   = frame_done_q | ack_last;
    assign wr_addr    = (head.fb_sel ? FB_BASE1[27:1] : FB_BASE0[27:1])
                        + ADDR_W'({head.idx, 2'b00});

    gba_fb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (DDRAM_CLK),
        .rst_n   (DDRAM_RESET_N),
        .push    (stg_valid),
        .din     (stg_q),
        .pop     (fifo_pop),
        .dout_c  (head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // Pixel packing; a completed word is staged for one cycle before entering the FIFO
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            lane      <= '0;
            idx       <= '0;
            pack_q    <= '0;
            stg_q     <= '0;
            stg_valid <= 1'b0;
        end else begin
            stg_valid <= 1'b0;
            if (fb.frame_start) begin
                idx <= '0;
                if (pix_accept) begin
                    pack_q[15:0] <= {1'b0, fb.pix_data};
                    lane         <= 2'd1;
                end else begin
                    lane <= 2'd0;
                end
            end else if (pix_accept && !frame_over) begin
                if (lane == 2'd3) begin
                    stg_q.fb_sel <= write_buf;
                    stg_q.idx    <= idx;
                    stg_q.data   <= {1'b0, fb.pix_data, pack_q};
                    stg_valid    <= 1'b1;
                    lane         <= 2'd0;
                    idx          <= idx + IDX_W'(1);
                end else begin
                    case (lane)
                        2'd0:    pack_q[15:0]  <= {1'b0, fb.pix_data};
                        2'd1:    pack_q[31:16] <= {1'b0, fb.pix_data};
                        default: pack_q[47:32] <= {1'b0, fb.pix_data};
                    endcase
                    lane <= lane + 2'd1;
                end
            end
        end
    end

    // Frame bookkeeping; the last-word acknowledge is folded in before frame_start
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            write_buf     <= 1'b0;
            display_buf_q <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            if (ack_last) begin
                frame_done_q  <= 1'b1;
                display_buf_q <= write_buf;
            end
            if (fb.frame_start) begin
                frame_done_q <= 1'b0;
                if (done_eff) begin
                    write_buf <= ~write_buf;
                end
            end
        end
    end

    // Write FSM next-state and control decode
    always_comb begin
        state_d  = state;
        req_d    = 1'b0;
        load     = 1'b0;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fb.ch5_ready) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write FSM state and registered channel-5 outputs
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            state  <= ST_IDLE;
            req_q  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            state <= state_d;
            req_q <= req_d;
            if (load) begin
                addr_q <= wr_addr;
                din_q  <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_gba_fb_writer.sv
// Directed self-checking bench for gba_fb_writer with an inline channel-5 arbiter model.
module tb_gba_fb_writer;

    localparam logic [26:0] BASE0_HW = 27'h0800000;
    localparam logic [26:0] BASE1_HW = 27'h0810000;

    logic DDRAM_CLK;
    logic DDRAM_RESET_N;

    gba_fb_if fb_if ();

    gba_fb_writer #(
        .FB_BASE0   (28'h1000000),
        .FB_BASE1   (28'h1020000),
        .FIFO_DEPTH (4)
    ) dut (
        .DDRAM_CLK     (DDRAM_CLK),
        .DDRAM_RESET_N (DDRAM_RESET_N),
        .fb            (fb_if)
    );

    initial DDRAM_CLK = 1'b0;
    always #5 DDRAM_CLK = ~DDRAM_CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc   = 0;
    int pr_low = 0;
    int stall = 0;
    int last_req_cyc = -1;
    bit pend  = 1'b0;
    logic [26:0] cap_addr [$];
    logic [63:0] cap_din  [$];

    function automatic logic [14:0] gen(input int i);
        int v;
        v = i * 37 + 11 + (i >>> 7);
        return 15'(v);
    endfunction

    function automatic logic [63:0] pack4(input logic [14:0] a, input logic [14:0] b,
                                          input logic [14:0] c, input logic [14:0] d);
        return {1'b0, d, 1'b0, c, 1'b0, b, 1'b0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: arbiter response, acceptance bookkeeping, then the edge
    task automatic tick();
        if (fb_if.ch5_req === 1'b1) begin
            cap_addr.push_back(fb_if.ch5_addr);
            cap_din.push_back(fb_if.ch5_din);
            last_req_cyc = cyc;
            pend = 1'b1;
            fb_if.ch5_ready = 1'b0;
        end else if (pend && stall > 0) begin
            stall--;
            fb_if.ch5_ready = 1'b0;
        end else if (pend) begin
            pend = 1'b0;
            fb_if.ch5_ready = 1'b1;
        end else begin
            fb_if.ch5_ready = 1'b0;
        end
        if (fb_if.pix_valid && fb_if.pix_ready)  acc++;
        if (fb_if.pix_valid && !fb_if.pix_ready) pr_low++;
        @(posedge DDRAM_CLK);
        #1;
        cyc++;
    endtask

    task automatic send(input logic fs, input logic [14:0] d);
        fb_if.pix_valid   = 1'b1;
        fb_if.pix_data    = d;
        fb_if.frame_start = fs;
        tick();
        fb_if.frame_start = 1'b0;
        fb_if.pix_valid   = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (cap_addr.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(cap_addr.size()), 64'(n));
    endtask

    task automatic do_reset();
        DDRAM_RESET_N     = 1'b0;
        pend              = 1'b0;
        stall             = 0;
        fb_if.ch5_ready   = 1'b0;
        fb_if.pix_valid   = 1'b0;
        fb_if.frame_start = 1'b0;
        fb_if.pix_data    = '0;
        repeat (3) tick();
        DDRAM_RESET_N = 1'b1;
        tick();
        cap_addr.delete();
        cap_din.delete();
        acc    = 0;
        pr_low = 0;
    endtask

    initial begin
        int t4;
        int err;

        // Reset values
        DDRAM_RESET_N     = 1'b0;
        fb_if.ch5_ready   = 1'b0;
        fb_if.pix_valid   = 1'b0;
        fb_if.frame_start = 1'b0;
        fb_if.pix_data    = '0;
        repeat (2) tick();
        chk("rst_ch5_req", 64'(fb_if.ch5_req), 64'd0);
        chk("rst_ch5_addr", 64'(fb_if.ch5_addr), 64'd0);
        chk("rst_ch5_din", fb_if.ch5_din, 64'd0);
        chk("rst_pix_ready", 64'(fb_if.pix_ready), 64'd1);
        chk("rst_display_buf", 64'(fb_if.display_buf), 64'd1);
        chk("rst_frame_done", 64'(fb_if.frame_done), 64'd0);

        // First word: packing, address and request latency
        do_reset();
        send(1'b0, 15'h7FFF);
        send(1'b0, 15'h0001);
        send(1'b0, 15'h1234);
        t4 = cyc;
        send(1'b0, 15'h0000);
        wait_writes(1, 20, "w1_count");
        chk("w1_req_latency", 64'(last_req_cyc), 64'(t4 + 3));
        chk("w1_addr", 64'(cap_addr[0]), 64'(BASE0_HW));
        chk("w1_din", cap_din[0], 64'h0000_1234_0001_7FFF);

        // Full frame plus four overflow pixels with immediate acknowledges
        do_reset();
        for (int i = 0; i < 38404; i++) begin
            send(i == 0, gen(i));
        end
        repeat (20) tick();
        chk("frm_accepted", 64'(acc), 64'd38404);
        chk("frm_ready_low", 64'(pr_low), 64'd0);
        chk("frm_writes", 64'(cap_addr.size()), 64'd9600);
        err = 0;
        for (int k = 0; k < cap_addr.size() && k < 9600; k++) begin
            if (cap_addr[k] !== BASE0_HW + 27'(4 * k) ||
                cap_din[k] !== pack4(gen(4*k), gen(4*k+1), gen(4*k+2), gen(4*k+3)))
                err++;
        end
        chk("frm_word_errors", 64'(err), 64'd0);
        chk("frm_last_addr", 64'(cap_addr[cap_addr.size()-1]), 64'h80_95FC);
        chk("frm_done", 64'(fb_if.frame_done), 64'd1);
        chk("frm_display_buf", 64'(fb_if.display_buf), 64'd0);
        cap_addr.delete();
        cap_din.delete();
        send(1'b1, 15'h0011);
        chk("frm2_done_clear", 64'(fb_if.frame_done), 64'd0);
        send(1'b0, 15'h0022);
        send(1'b0, 15'h0033);
        send(1'b0, 15'h0044);
        wait_writes(1, 20, "frm2_count");
        chk("frm2_addr", 64'(cap_addr[0]), 64'(BASE1_HW));
        chk("frm2_din", cap_din[0], pack4(15'h0011, 15'h0022, 15'h0033, 15'h0044));

        // Arbiter held off: FIFO fills and pixel flow stalls at lane 3
        do_reset();
        stall = 50;
        for (int i = 0; i < 40; i++) begin
            send(i == 0, gen(acc));
        end
        chk("stall_accepted", 64'(acc), 64'd19);
        chk("stall_pix_ready", 64'(fb_if.pix_ready), 64'd0);
        for (int i = 0; i < 400 && acc < 32; i++) begin
            send(1'b0, gen(acc));
        end
        chk("stall_resume", 64'(acc), 64'd32);
        wait_writes(8, 200, "stall_writes");
        repeat (10) tick();
        chk("stall_no_extra", 64'(cap_addr.size()), 64'd8);
        err = 0;
        for (int k = 0; k < cap_addr.size() && k < 8; k++) begin
            if (cap_addr[k] !== BASE0_HW + 27'(4 * k) ||
                cap_din[k] !== pack4(gen(4*k), gen(4*k+1), gen(4*k+2), gen(4*k+3)))
                err++;
        end
        chk("stall_word_errors", 64'(err), 64'd0);
        chk("stall_ready_back", 64'(fb_if.pix_ready), 64'd1);

        // Frame restarted after 5002 pixels: partial word dropped, buffer 0 rewritten
        do_reset();
        for (int i = 0; i < 5002; i++) begin
            send(i == 0, gen(i));
        end
        send(1'b1, 15'h0AAA);
        chk("rs_display_buf", 64'(fb_if.display_buf), 64'd1);
        send(1'b0, 15'h0BBB);
        send(1'b0, 15'h0CCC);
        send(1'b0, 15'h0DDD);
        wait_writes(1251, 40, "rs_writes");
        repeat (10) tick();
        chk("rs_no_extra", 64'(cap_addr.size()), 64'd1251);
        chk("rs_old_addr", 64'(cap_addr[1249]), 64'(BASE0_HW + 27'd4996));
        chk("rs_old_din", cap_din[1249], pack4(gen(4996), gen(4997), gen(4998), gen(4999)));
        chk("rs_new_addr", 64'(cap_addr[1250]), 64'(BASE0_HW));
        chk("rs_new_din", cap_din[1250], pack4(15'h0AAA, 15'h0BBB, 15'h0CCC, 15'h0DDD));
        chk("rs_display_after", 64'(fb_if.display_buf), 64'd1);
        chk("rs_frame_done", 64'(fb_if.frame_done), 64'd0);

        // Reset while a request waits for acknowledge
        do_reset();
        stall = 50;
        send(1'b1, 15'h0101);
        send(1'b0, 15'h0202);
        send(1'b0, 15'h0303);
        send(1'b0, 15'h0404);
        wait_writes(1, 20, "rw_req");
        tick();
        DDRAM_RESET_N   = 1'b0;
        pend            = 1'b0;
        stall           = 0;
        fb_if.ch5_ready = 1'b0;
        @(posedge DDRAM_CLK);
        #1;
        chk("rw_ch5_req", 64'(fb_if.ch5_req), 64'd0);
        chk("rw_ch5_addr", 64'(fb_if.ch5_addr), 64'd0);
        chk("rw_ch5_din", fb_if.ch5_din, 64'd0);
        chk("rw_pix_ready", 64'(fb_if.pix_ready), 64'd1);
        chk("rw_display_buf", 64'(fb_if.display_buf), 64'd1);
        DDRAM_RESET_N = 1'b1;
        tick();
        cap_addr.delete();
        cap_din.delete();
        send(1'b1, 15'h0505);
        send(1'b0, 15'h0606);
        send(1'b0, 15'h0707);
        send(1'b0, 15'h0808);
        wait_writes(1, 20, "rw_new_count");
        chk("rw_new_addr", 64'(cap_addr[0]), 64'(BASE0_HW));
        chk("rw_new_din", cap_din[0], pack4(15'h0505, 15'h0606, 15'h0707, 15'h0808));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gba_fb_writer.md
# gba_fb_writer

Framebuffer write scheduler that sits between the GPU pixel output and DDRAM channel 5 (framebuffer) of the DDR3 arbiter. It packs 15-bit GBA pixels four-per-64-bit word, buffers completed words in a small FIFO and issues one channel-5 write request at a time. It also double-buffers whole frames in DDR, so the scanout side only ever sees a completely written frame.

## Interface
Parameters:
- FB_BASE0, 28'h1000000, byte address of frame buffer 0 (64-bit aligned)
- FB_BASE1, 28'h1020000, byte address of frame buffer 1 (64-bit aligned)
- FIFO_DEPTH, 4, completed-word FIFO entries (power of 2, ≥2)

Ports:
- DDRAM_CLK  in  1  sole clock
- DDRAM_RESET_N  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of each GPU frame
- pix_valid  in  1  pixel present
- pix_data  in  15  BGR555 pixel
- pix_ready  out  1  pixel accepted this cycle when pix_valid & pix_ready
- ch5_addr  out  27  halfword address [27:1] to arbiter
- ch5_din  out  64  write data to arbiter
- ch5_req  out  1  one-cycle write request pulse
- ch5_ready  in  1  one-cycle pulse: arbiter has issued the write
- display_buf  out  1  buffer index scanout reads (last completed frame)
- frame_done  out  1  current frame fully written to DDR

## Operation
- Frame geometry is fixed: 240×160 = 38400 pixels = 9600 words; word index idx is 14 bits, 0..9599.
- Packing: lane counter 0..3; pixel in lane n goes to bits [16n+14:16n], bit 16n+15 = 0. Lane 3 completes the word, which is pushed to the FIFO as {buf, idx, data}, and idx increments.
- Pixels beyond index 38399 in a frame are accepted (pix_ready=1) and dropped.
- pix_ready = ~(fifo_full & lane==3).
- Write FSM states:
  - IDLE: if FIFO is non-empty, load ch5_addr/ch5_din from the head and go to REQ.
  - REQ: ch5_req=1 for exactly one cycle, then WAIT.
  - WAIT: on ch5_ready, pop the head and go to IDLE.
- At most one request is outstanding.
- Address: ch5_addr = (buf ? FB_BASE1 : FB_BASE0)[27:1] + {idx,2'b00}, 27-bit arithmetic.
- Completion: when ch5_ready acknowledges idx 9599 of the current write buffer, set frame_done and display_buf <= write_buf.
- frame_start:
  - lane and idx reset to 0; any partial word is discarded.
  - If frame_done, write_buf toggles; otherwise write_buf is unchanged, so the incomplete frame is overwritten and never shown.
  - frame_done clears.
  - FIFO entries keep their tagged buf/idx and still drain.
- frame_start coincident with a pixel: frame_start wins, and the pixel is the first pixel (lane 0) of the new frame.
- Acknowledgement of word 9599 in the same cycle as frame_start: the acknowledgement is processed first, so display updates and write_buf toggles.

## Timing
- Reset values:
  - Internal state: write_buf=0, display_buf=1, frame_done=0, lane=0, idx=0, FIFO empty, FSM IDLE.
  - Outputs: ch5_req=0, ch5_addr=0, ch5_din=0, pix_ready=1.
- Latency: the 4th pixel accepted in cycle t is written to the FIFO at t+1; ch5_req asserts at t+3 if the FSM was IDLE.
- FIFO push and pop in the same cycle are allowed, including when full (pop frees the entry).
- Throughput is bounded by the arbiter: one word per ch5_ready plus 2 cycles.
- Reset mid-request abandons it; the arbiter's latched request completes harmlessly.

## Structure
- Package gba_fb_pkg holds FB_W=240, FB_H=160, WORDS_PER_FRAME=9600, IDX_W=14, and the FSM enum typedef (IDLE, REQ, WAIT).
- Sub-module gba_fb_fifo: synchronous FIFO of width 1+IDX_W+64, with parameterised depth, full/empty flags and async active-low reset.

## Test plan
- Reset then 4 pixels 0x7FFF,0x0001,0x1234,0x0000 -> one ch5_req, ch5_addr=FB_BASE0[27:1], ch5_din=64'h0000_1234_0001_7FFF.
- Full 38400-pixel frame with immediate ch5_ready -> 9600 writes, last at FB_BASE0[27:1]+9599*4; frame_done=1; display_buf=0; next frame writes FB_BASE1.
- ch5_ready held off 50 cycles with continuous pixels -> FIFO fills, pix_ready drops exactly when fifo_full & lane==3, no pixel lost or duplicated.
- frame_start after 5000 pixels -> display_buf stays 1, next frame rewrites buffer 0 starting at idx 0; queued words still written with original addresses.
- 38404 pixels in one frame -> exactly 9600 writes; extra pixels dropped with pix_ready=1.
- Reset asserted while in WAIT -> all outputs at reset values next edge; new frame starts at FB_BASE0.
